// File: rtl/gate_stim_checker.sv
// gate_stim_checker: exhaustive self-test sequencer for a four-gate stage
// (AND, NAND, OR, XOR). It walks all 256 stimulus vectors. For each vector it
// waits SETTLE_CYCLES cycles, then compares the gate responses with the ideal
// truth table and records the error count and the first failing vector.
// Optional feature: define GATE_STIM_CHECKER_MASK_EN to add resp_mask[3:0].
// A bit set in resp_mask is excluded from the comparison.
module gate_stim_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
`ifdef GATE_STIM_CHECKER_MASK_EN
  input  logic [3:0] resp_mask,
`endif
  input  logic [3:0] resp_in,
  output logic [7:0] stim_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       fail_valid,
  output logic [7:0] first_fail
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_e     state_r;
  logic [3:0] settle_cnt_r;
  logic [3:0] exp_resp_s;
  logic [3:0] cmp_mask_s;
  logic       mismatch_s;
  logic [7:0] err_next_s;

  // Ideal response of the gate stage for one stimulus vector.
  function automatic logic [3:0] gate_expect(input logic [7:0] s);
    logic [3:0] r;
    r[0] = s[0] & s[1];
    r[1] = ~(s[2] & s[3]);
    r[2] = s[4] | s[5];
    r[3] = s[6] ^ s[7];
    return r;
  endfunction

  // Compare the response with the ideal result and compute the saturating next error count.
  always_comb begin
    exp_resp_s = gate_expect(stim_out);
`ifdef GATE_STIM_CHECKER_MASK_EN
    cmp_mask_s = ~resp_mask;
`else
    cmp_mask_s = 4'hF;
`endif
    mismatch_s = |((resp_in ^ exp_resp_s) & cmp_mask_s);
    if (mismatch_s && (err_count != 8'hFF)) begin
      err_next_s = err_count + 8'd1;
    end else begin
      err_next_s = err_count;
    end
  end

  // Sequencer FSM. It holds all state and registered outputs while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      settle_cnt_r <= 4'd0;
      stim_out     <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= 8'h00;
      fail_valid   <= 1'b0;
      first_fail   <= 8'h00;
    end else if (ena) begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r    <= DRIVE;
            stim_out   <= 8'h00;
            err_count  <= 8'h00;
            fail_valid <= 1'b0;
            first_fail <= 8'h00;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        DRIVE: begin
          state_r      <= SETTLE;
          settle_cnt_r <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt_r <= 4'd1) begin
            settle_cnt_r <= 4'd0;
            state_r      <= CHECK;
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        CHECK: begin
          err_count <= err_next_s;
          if (mismatch_s && !fail_valid) begin
            fail_valid <= 1'b1;
            first_fail <= stim_out;
          end
          if (stim_out == 8'hFF) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next_s == 8'h00);
          end else begin
            stim_out <= stim_out + 8'd1;
            state_r  <= DRIVE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Self-checking bench for gate_stim_checker. A behavioural gate model, with
// optional fault injection, drives resp_in. The expected run results are
// queued when each run is started, then popped and compared when done rises.
module tb_gate_stim_checker;

  localparam int S       = 2;
  localparam int RUN_LAT = 256 * (S + 2);

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [3:0] resp_in;
  logic [3:0] resp_mask;
  logic [7:0] stim_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic       fail_valid;
  logic [7:0] first_fail;

  int checks;
  int errors;
  int fault_mode;  // 0 ideal, 1 resp[3] stuck at 0, 2 resp[1] inverted

  typedef struct {
    logic [7:0] err;
    logic [7:0] first;
    logic       fvalid;
    logic       pass_v;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  gate_stim_checker #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
`ifdef GATE_STIM_CHECKER_MASK_EN
    .resp_mask  (resp_mask),
`endif
    .resp_in    (resp_in),
    .stim_out   (stim_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .first_fail (first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural gate stage, with the selected fault applied.
  always_comb begin
    resp_in[0] = stim_out[0] & stim_out[1];
    resp_in[1] = ~(stim_out[2] & stim_out[3]);
    resp_in[2] = stim_out[4] | stim_out[5];
    resp_in[3] = stim_out[6] ^ stim_out[7];
    if (fault_mode == 1) resp_in[3] = 1'b0;
    if (fault_mode == 2) resp_in[1] = ~resp_in[1];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts a run, optionally pulses start during the CHECK of vector inj, and scores the result.
  task automatic do_run(input int mode, input logic [7:0] e_err, input logic [7:0] e_first,
                        input logic e_fv, input logic e_pass, input int inj);
    exp_t e;
    exp_t got_e;
    int   cycles;
    bit   seen;
    fault_mode = mode;
    e.err = e_err; e.first = e_first; e.fvalid = e_fv; e.pass_v = e_pass; e.lat = RUN_LAT;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    cycles = 0;
    seen = 1'b0;
    while (cycles < RUN_LAT + 50) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (cycles == 1) begin
        check_eq("accept_busy", {31'd0, busy}, 32'd1);
        check_eq("accept_stim", {24'd0, stim_out}, 32'h00);
        check_eq("accept_err_cleared", {24'd0, err_count}, 32'd0);
        check_eq("accept_fv_cleared", {31'd0, fail_valid}, 32'd0);
        check_eq("accept_done_pass", {30'd0, done, pass}, 32'd0);
      end
      if (cycles == 500) begin
        check_eq("midrun_done_pass", {30'd0, done, pass}, 32'd0);
      end
      if (inj >= 0 && cycles == (inj + 1) * (S + 2)) begin
        check_eq("inject_stim", {24'd0, stim_out}, inj);
        start = 1'b1;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check_eq("done_timeout", 32'd0, 32'd1);
    end else begin
      got_e = sb_q.pop_front();
      check_eq("latency", cycles - 1, got_e.lat);
      check_eq("err_count", {24'd0, err_count}, {24'd0, got_e.err});
      check_eq("first_fail", {24'd0, first_fail}, {24'd0, got_e.first});
      check_eq("fail_valid", {31'd0, fail_valid}, {31'd0, got_e.fvalid});
      check_eq("pass", {31'd0, pass}, {31'd0, got_e.pass_v});
      check_eq("done_busy", {31'd0, busy}, 32'd0);
      check_eq("done_stim", {24'd0, stim_out}, 32'hFF);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_stim"}, {24'd0, stim_out}, 32'h00);
    check_eq({tag, "_flags"}, {28'd0, busy, done, pass, fail_valid}, 32'd0);
    check_eq({tag, "_err"}, {24'd0, err_count}, 32'd0);
    check_eq({tag, "_first"}, {24'd0, first_fail}, 32'd0);
  endtask

  initial begin
    int   k;
    logic [7:0] held;
    checks = 0;
    errors = 0;
    fault_mode = 0;
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    resp_mask = 4'h0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Ideal gates: clean pass, 1024-cycle run.
    do_run(0, 8'd0, 8'h00, 1'b0, 1'b1, -1);
    // XOR output stuck at 0.
    do_run(1, 8'd128, 8'h40, 1'b1, 1'b0, -1);
    // NAND output inverted: every vector fails, count saturates.
    do_run(2, 8'd255, 8'h00, 1'b1, 1'b0, -1);
    // start during CHECK of 0x10 is ignored, run still completes normally.
    do_run(1, 8'd128, 8'h40, 1'b1, 1'b0, 8'h10);
    // Restart from DONE clears the error state.
    do_run(0, 8'd0, 8'h00, 1'b0, 1'b1, -1);

    // Mid-run hold at 0x37, then reset while still held.
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (stim_out != 8'h37 && k < RUN_LAT) begin
      @(negedge clk);
      k++;
    end
    check_eq("reach_37", {24'd0, stim_out}, 32'h37);
    ena = 1'b0;
    held = err_count;
    repeat (10) @(negedge clk);
    check_eq("hold_stim", {24'd0, stim_out}, 32'h37);
    check_eq("hold_busy", {31'd0, busy}, 32'd1);
    check_eq("hold_err", {24'd0, err_count}, {24'd0, held});
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrun_reset");
    rst_n = 1'b1;
    ena = 1'b1;

`ifdef GATE_STIM_CHECKER_MASK_EN
    // Masking the stuck XOR bit makes the run pass.
    resp_mask = 4'h8;
    do_run(1, 8'd0, 8'h00, 1'b0, 1'b1, -1);
    resp_mask = 4'h0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_stim_checker.md
GATE_STIM_CHECKER -- requirements
Module: gate_stim_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, range 1..15: idle cycles between driving a vector and sampling the response.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ena  input  1  high = advance; low = hold all state and outputs.
REQ-005 SHALL have port start  input  1  begin an exhaustive run; sampled in IDLE and DONE only.
REQ-006 SHALL have port stim_out  output  8  vector driven to the gate stage (pairs [1:0],[3:2],[5:4],[7:6]).
REQ-007 SHALL have port resp_in  input  4  gate results: [0]=AND(s0,s1), [1]=NAND(s2,s3), [2]=OR(s4,s5), [3]=XOR(s6,s7).
REQ-008 SHALL have port busy  output  1  high while a run is in progress.
REQ-009 SHALL have port done  output  1  high in DONE state.
REQ-010 SHALL have port pass  output  1  high in DONE when err_count==0.
REQ-011 SHALL have port err_count  output  8  mismatching vectors, saturating at 255.
REQ-012 SHALL have port fail_valid  output  1  high once any mismatch is recorded.
REQ-013 SHALL have port first_fail  output  8  stim value of the first mismatching vector.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-015 IDLE/DONE + start=1 SHALL go to DRIVE with stim_out=0x00, and clear err_count, fail_valid, and first_fail.
REQ-016 DRIVE SHALL last 1 cycle, then go to SETTLE with the settle counter loaded to SETTLE_CYCLES.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-018 CHECK (1 cycle) SHALL compare resp_in with the expected value computed from stim_out.
REQ-019 On a mismatch in CHECK, err_count SHALL increment unless already 255.
REQ-020 On a mismatch in CHECK with fail_valid=0, first_fail SHALL load stim_out and fail_valid SHALL be set.
REQ-021 After CHECK, if stim_out==0xFF the FSM SHALL go to DONE; otherwise stim_out SHALL increment by 1 and the FSM SHALL go to DRIVE.
REQ-022 stim_out SHALL be stable from DRIVE through CHECK of each vector and SHALL NOT wrap past 0xFF.
REQ-023 Per-vector latency SHALL be SETTLE_CYCLES+2 cycles; a full run from start accept to done rise SHALL take 256*(SETTLE_CYCLES+2) cycles.
REQ-024 start SHALL be ignored in DRIVE, SETTLE, and CHECK.
REQ-025 busy SHALL be high exactly in DRIVE, SETTLE, and CHECK.
REQ-026 stim_out SHALL retain its last value (0xFF) in DONE.
REQ-027 ena=0 SHALL freeze the FSM, counters, and outputs, including mid-settle; counting SHALL resume where it stopped.
REQ-028 pass SHALL be 0 outside DONE.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-run, regardless of ena.
REQ-030 Reset values SHALL be: stim_out=0x00, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0x00, settle counter=0.
REQ-031 The first start SHALL be accepted on the first edge after rst_n returns high.

Configuration
REQ-032 With GATE_STIM_CHECKER_MASK_EN defined, the block SHALL add input resp_mask[3:0], and any bit with resp_mask=1 SHALL be excluded from the CHECK comparison.
REQ-033 With GATE_STIM_CHECKER_MASK_EN defined and resp_mask=4'hF, every vector SHALL pass.
REQ-034 Without GATE_STIM_CHECKER_MASK_EN, resp_mask SHALL be absent and all 4 bits SHALL be compared.

Verification
REQ-035 Ideal gate model, SETTLE_CYCLES=2, start pulse -> done rises 1024 cycles later, pass=1, err_count=0, fail_valid=0.
REQ-036 Model with resp_in[3] stuck at 0 -> err_count=128, first_fail=0x40, pass=0.
REQ-037 Model with resp_in[1] inverted -> err_count=255 (saturated), first_fail=0x00.
REQ-038 Mid-run (stim_out=0x37): ena low 10 cycles, then rst_n low 1 cycle -> stim_out frozen at 0x37 during hold, then IDLE with all outputs at reset values.
REQ-039 start pulsed during CHECK of 0x10 -> ignored; the run completes normally; restart from DONE clears err_count.
REQ-040 GATE_STIM_CHECKER_MASK_EN defined, resp_mask=4'h8, resp_in[3] stuck at 0 -> pass=1.
